password_lock: RTL

- Parametrised keypad password checker; successor to the fixed 4-digit checker.
- Collects DIGITS key codes of DW bits and compares them against an internally stored password.
- Counts failed attempts and enters a timed lockout after MAX_TRIES failures.
- Lets the password be reprogrammed after a successful unlock. Sits between the keypad debouncer/encoder and the display/indicator logic.

---
 rtl/password_lock.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/password_lock.sv
// Keypad password checker: collects DIGITS key codes, compares them against a stored
// password, locks out after MAX_TRIES consecutive failures, and allows reprogramming after a pass.
module password_lock #(
    parameter int DIGITS      = 4,
    parameter int DW          = 4,
    parameter int MAX_TRIES   = 3,
    parameter int LOCK_CYCLES = 1000,
    parameter logic [DIGITS*DW-1:0] DEFAULT_PWD = 16'h1234
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 enable,
    input  logic                 key_event,
    input  logic [DW-1:0]        key_value,
    input  logic                 key_clr,
    input  logic                 prog_req,
    output logic [DIGITS*DW-1:0] entry,
    output logic [3:0]           entry_cnt,
    output logic                 true_out,
    output logic                 false_out,
    output logic                 locked,
    output logic                 prog_active,
    output logic                 prog_done,
    output logic [3:0]           fail_cnt
);
    localparam int W  = DIGITS * DW;
    localparam int TW = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;
    localparam logic [TW-1:0] LOCK_LOAD = TW'(LOCK_CYCLES - 1);
    localparam logic [3:0]    CNT_FULL  = 4'(DIGITS);
    localparam logic [3:0]    CNT_LAST  = 4'(DIGITS - 1);
    localparam logic [3:0]    TRIES     = 4'(MAX_TRIES);

    typedef enum logic [2:0] {
        S_IDLE, S_COLLECT, S_CHECK, S_PASS, S_FAIL, S_LOCKOUT, S_PROGRAM
    } state_t;

    state_t          r_state, w_nstate;
    logic [W-1:0]    r_entry, w_nentry, r_pwd, w_npwd;
    logic [3:0]      r_cnt, w_ncnt, r_fail, w_nfail, w_fail_inc;
    logic [TW-1:0]   r_timer, w_ntimer;
    logic            r_key_q;
    logic            w_take, w_commit;
    logic [W-1:0]    w_shift, w_first;
    logic            r_true, r_false, r_locked, r_prog_active, r_prog_done;

    // Edge history is tracked even while disabled so a press during enable=0 is lost, not queued.
    assign w_take     = enable & key_event & ~r_key_q;
    assign w_shift    = {r_entry[W-DW-1:0], key_value};
    assign w_first    = {{(W-DW){1'b0}}, key_value};
    assign w_fail_inc = r_fail + 4'd1;

    always_comb begin
        w_nstate = r_state;
        w_nentry = r_entry;
        w_ncnt   = r_cnt;
        w_nfail  = r_fail;
        w_ntimer = r_timer;
        w_npwd   = r_pwd;
        w_commit = 1'b0;
        if (enable) begin
            case (r_state)
                S_IDLE, S_FAIL: begin
                    if (w_take) begin
                        w_nentry = w_first;
                        w_ncnt   = 4'd1;
                        w_nstate = S_COLLECT;
                    end
                end
                S_PASS: begin
                    if (prog_req) begin
                        w_nstate = S_PROGRAM;
                        w_nentry = '0;
                        w_ncnt   = '0;
                    end else if (w_take) begin
                        w_nentry = w_first;
                        w_ncnt   = 4'd1;
                        w_nstate = S_COLLECT;
                    end
                end
                S_COLLECT: begin
                    if (key_clr) begin
                        w_nentry = '0;
                        w_ncnt   = '0;
                    end else if (r_cnt == CNT_FULL) begin
                        w_nstate = S_CHECK;
                    end else if (w_take) begin
                        w_nentry = w_shift;
                        w_ncnt   = r_cnt + 4'd1;
                    end
                end
                S_CHECK: begin
                    if (r_entry == r_pwd) begin
                        w_nstate = S_PASS;
                        w_nfail  = '0;
                    end else begin
                        w_nfail  = w_fail_inc;
                        if (w_fail_inc == TRIES) begin
                            w_nstate = S_LOCKOUT;
                            w_ntimer = LOCK_LOAD;
                        end else begin
                            w_nstate = S_FAIL;
                        end
                    end
                end
                S_LOCKOUT: begin
                    if (r_timer == '0) begin
                        w_nstate = S_IDLE;
                        w_nfail  = '0;
                        w_nentry = '0;
                        w_ncnt   = '0;
                    end else begin
                        w_ntimer = r_timer - 1'b1;
                    end
                end
                S_PROGRAM: begin
                    if (key_clr) begin
                        w_nentry = '0;
                        w_ncnt   = '0;
                    end else if (w_take) begin
                        if (r_cnt == CNT_LAST) begin
                            w_npwd   = w_shift;
                            w_commit = 1'b1;
                            w_nentry = '0;
                            w_ncnt   = '0;
                            w_nstate = S_IDLE;
                        end else begin
                            w_nentry = w_shift;
                            w_ncnt   = r_cnt + 4'd1;
                        end
                    end
                end
                default: w_nstate = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state       <= S_IDLE;
            r_entry       <= '0;
            r_cnt         <= '0;
            r_fail        <= '0;
            r_timer       <= '0;
            r_pwd         <= DEFAULT_PWD;
            r_key_q       <= 1'b0;
            r_true        <= 1'b0;
            r_false       <= 1'b0;
            r_locked      <= 1'b0;
            r_prog_active <= 1'b0;
            r_prog_done   <= 1'b0;
        end else begin
            r_state       <= w_nstate;
            r_entry       <= w_nentry;
            r_cnt         <= w_ncnt;
            r_fail        <= w_nfail;
            r_timer       <= w_ntimer;
            r_pwd         <= w_npwd;
            r_key_q       <= key_event;
            r_true        <= (w_nstate == S_PASS);
            r_false       <= (w_nstate == S_FAIL);
            r_locked      <= (w_nstate == S_LOCKOUT);
            r_prog_active <= (w_nstate == S_PROGRAM);
            r_prog_done   <= w_commit;
        end
    end

    assign entry       = r_entry;
    assign entry_cnt   = r_cnt;
    assign fail_cnt    = r_fail;
    assign true_out    = r_true;
    assign false_out   = r_false;
    assign locked      = r_locked;
    assign prog_active = r_prog_active;
    assign prog_done   = r_prog_done;
endmodule
